// File: rtl/led_rr_arbiter.sv
// Round-robin arbiter for the shared one-hot LED / 2-to-4 decoder resource.
// Grants last between MIN_HOLD and MAX_HOLD cycles and are separated by one dead cycle.
module led_rr_arbiter #(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       last_ptr;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       winner_found;
    logic       owner_req;
    logic       min_reached;
    logic       max_reached;
    logic       release_now;

    // Search starts just after the last owner; k=4 wraps back onto it, so it is ranked last.
    always_comb begin
        winner       = 2'd0;
        cand         = 2'd0;
        winner_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + 2'(k);
            if (!winner_found && req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    assign owner_req   = req[gnt_idx];
    assign min_reached = (hold_cnt >= MIN_CNT);
    assign max_reached = (hold_cnt == MAX_CNT);
    assign release_now = (!owner_req && min_reached) || max_reached;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last_ptr  <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (en && winner_found) begin
                        gnt       <= 4'b0001 << winner;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        last_ptr  <= winner;
                        state     <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // gnt_idx is left alone on release so the decoder select stays stable.
                    if (release_now) begin
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        timeout   <= max_reached && owner_req;
                        state     <= GAP;
                    end else if (!max_reached) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_rr_arbiter.sv
// Directed bench for led_rr_arbiter: rotation, hold limits, timeout, enable and reset.
module tb_led_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    led_rr_arbiter #(
        .MIN_HOLD(4),
        .MAX_HOLD(64),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eg, input logic [1:0] eidx, input logic et);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(eg));
        checkOutput({tag, "_idx"}, 32'(gnt_idx), 32'(eidx));
        checkOutput({tag, "_valid"}, 32'(gnt_valid), 32'(|eg));
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(et));
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q);
        rst = r;
        en  = e;
        req = q;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [3:0] oh;
        applyStimulus(1'b1, 1'b0, 4'b0000);
        step(2);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        step(1);
        checkAll("reset", 4'b0000, 2'd0, 1'b0);

        $display("[TB] rotation with all requesters");
        applyStimulus(1'b0, 1'b1, 4'b1111);
        step(1);
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order[i];
            checkAll($sformatf("rot%0d_first", i), oh, 2'(order[i]), 1'b0);
            req[order[i]] = 1'b0;
            if (i == 3) req[0] = 1'b1;
            for (int c = 1; c < 4; c++) begin
                step(1);
                checkOutput($sformatf("rot%0d_hold%0d", i, c), 32'(gnt), 32'(oh));
            end
            step(1);
            checkAll($sformatf("rot%0d_gap", i), 4'b0000, 2'(order[i]), 1'b0);
            step(1);
        end
        checkAll("rot_idle", 4'b0000, 2'd0, 1'b0);

        $display("[TB] single-cycle pulse on req[2]");
        req = 4'b0100;
        step(1);
        req = 4'b0000;
        checkAll("pulse_first", 4'b0100, 2'd2, 1'b0);
        for (int c = 1; c < 4; c++) begin
            step(1);
            checkOutput($sformatf("pulse_hold%0d", c), 32'(gnt), 32'h4);
        end
        step(1);
        checkAll("pulse_gap", 4'b0000, 2'd2, 1'b0);

        $display("[TB] continuous req[1] hits max hold");
        req = 4'b0010;
        step(1);
        checkAll("max_first", 4'b0010, 2'd1, 1'b0);
        for (int c = 1; c < 64; c++) begin
            step(1);
            checkOutput($sformatf("max_hold%0d", c), 32'(gnt), 32'h2);
        end
        step(1);
        checkAll("max_release", 4'b0000, 2'd1, 1'b1);
        step(1);
        checkAll("max_regrant", 4'b0010, 2'd1, 1'b0);

        $display("[TB] req[3] raised during a long grant to 1");
        step(10);
        req = 4'b1010;
        step(1);
        checkAll("mid_ignore", 4'b0010, 2'd1, 1'b0);
        step(53);
        checkAll("mid_release", 4'b0000, 2'd1, 1'b1);
        step(1);
        checkAll("mid_to3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0010;
        step(3);
        checkOutput("mid_hold3", 32'(gnt), 32'h8);
        step(1);
        checkAll("mid_gap3", 4'b0000, 2'd3, 1'b0);
        step(1);
        checkAll("mid_back1", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step(5);
        checkAll("mid_done", 4'b0000, 2'd1, 1'b0);

        $display("[TB] enable gating");
        applyStimulus(1'b1, 1'b0, 4'b0000);
        step(1);
        applyStimulus(1'b0, 1'b0, 4'b0101);
        step(3);
        checkAll("en_off", 4'b0000, 2'd0, 1'b0);
        en = 1'b1;
        step(1);
        checkAll("en_on", 4'b0001, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0100);
        step(3);
        checkAll("en_cleared_hold", 4'b0001, 2'd0, 1'b0);
        step(1);
        checkAll("en_cleared_rel", 4'b0000, 2'd0, 1'b0);
        step(3);
        checkAll("en_no_regrant", 4'b0000, 2'd0, 1'b0);

        $display("[TB] reset in the middle of a grant");
        applyStimulus(1'b0, 1'b1, 4'b1000);
        step(1);
        checkAll("rst_pre", 4'b1000, 2'd3, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);
        checkAll("rst_mid", 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1001);
        step(1);
        checkAll("rst_after", 4'b0001, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
